// File: rtl/uart_tx_feed_fifo.sv
// Byte FIFO plus IDLE/SEND/GAP sequencer feeding a UART transmitter.
// Optional overflow flag: define TX_FEED_OVF_FLAG_EN to add OVF_Clr/OVF_Flag.
module uart_tx_feed_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        WR_Data,
  input  logic              WR_En,
  output logic              WR_Full,
  output logic              WR_Empty,
  output logic [ADDR_W:0]   Count,
  output logic [7:0]        TX_Data,
  output logic              TX_En_Sig,
  input  logic              TX_Done_Sig,
`ifdef TX_FEED_OVF_FLAG_EN
  input  logic              OVF_Clr,
  output logic              OVF_Flag,
`endif
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q;
  logic              pop, push, drop;

  state_t            state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;

  // A pop frees a slot on the same edge, so a full FIFO still accepts then.
  assign pop  = (state_q == IDLE) && !empty_q;
  assign push = WR_En && (!full_q || pop);
  assign drop = WR_En && !push;

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: storage is not reset; pointers and flags alone decide which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WR_Data;
  end

  always_comb begin
    state_d   = state_q;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: if (!empty_q) begin
        state_d   = SEND;
        tx_en_d   = 1'b1;
        tx_data_d = mem[rd_ptr];
      end
      SEND: if (TX_Done_Sig) begin
        state_d = GAP;
        tx_en_d = 1'b0;
      end
      // One low cycle lets the transmitter rearm before the next frame.
      GAP:  state_d = IDLE;
      default: begin
        state_d = IDLE;
        tx_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef TX_FEED_OVF_FLAG_EN
  logic ovf_q;
  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge CLK) begin
    if (RST)          ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (OVF_Clr) ovf_q <= 1'b0;
  end
  assign OVF_Flag = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign WR_Full   = full_q;
  assign WR_Empty  = empty_q;
  assign Count     = count_q;
  assign TX_Data   = tx_data_q;
  assign TX_En_Sig = tx_en_q;
  assign Busy      = (state_q != IDLE) || !empty_q;

endmodule
